clk_div_bank: RTL
=================

# clk_div_bank

Parametrised multi-channel clock-enable/divided-clock generator for the VGA pipeline: derives pixel, scan and blink timebases from the single system clock. Each channel has a runtime-programmable divisor applied glitch-free at its period boundary, a near-50 % duty divided-clock level and a one-cycle `tick` enable. A global `resync` phase-aligns all channels.

## Interface
- `CHANNELS`, 2: number of independent divider channels (1..8).
- `CNT_W`, 16: divisor and counter width.
- `DIV_RESET`, 4: divisor loaded into every channel at reset (2..2^CNT_W-1).
- `SEL_W`, derived: `max(1, clog2(CHANNELS))`.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  CHANNELS  per-channel run enable.
- `resync`  in  1  one-cycle strobe; restarts every channel in phase.
- `div_wr`  in  1  divisor write strobe.
- `div_sel`  in  SEL_W  target channel for `div_wr`.
- `div_val`  in  CNT_W  new divisor D.
- `clk_out`  out  CHANNELS  divided clock level; registered.
- `tick`  out  CHANNELS  one-cycle pulse in the last cycle of each period; registered.
- `pending`  out  CHANNELS  divisor write waiting for its period boundary.

## Operation
- Per channel: `cnt` runs 0..D-1, with active divisor `div`, pending register `nxt` and flag `pending`.
- Registered outputs follow the post-edge `cnt`: `clk_out = (cnt < H)` with `H = D - floor(D/2)`, so clk_out is high for ceil(D/2) cycles and low for floor(D/2). `tick = (cnt == D-1)` on enabled edges only.
- Reset: `cnt = DIV_RESET-1`, `div = nxt = DIV_RESET`, `clk_out = 0`, `tick = 0`, `pending = 0`.
- Enabled edge: `cnt` increments. At `cnt == D-1`, it wraps to 0. On that wrap, if `pending` is set, `div <= nxt` and `pending <= 0`, and the new period uses the new D.
- `en` low: `cnt`, `div` and `clk_out` hold. `tick` goes 0 on the next edge. Pending writes wait until the channel wraps.
- `div_wr`: if `div_sel >= CHANNELS`, the write is ignored. Otherwise `nxt <= clamp(div_val)` and `pending <= 1`. A write while already pending overwrites `nxt`.
- Clamp: a written D of 0 or 1 becomes 2. There is no other width arithmetic, because `cnt` never exceeds D-1.
- `resync` applies to all channels regardless of `en`, and takes priority over counting: `cnt <= 0`, `clk_out <= 1`, `tick <= 0`, and if pending then `div <= nxt`, `pending <= 0`.
- Simultaneous events:
  - `div_wr` in the same cycle as a wrap: the wrap uses the previously pending value, if any. The new write stays pending until the next wrap.
  - `div_wr` in the same cycle as `resync`: `resync` consumes the old `nxt`, and the new write becomes pending.
- Reset asserted mid-period: all channels return to reset values immediately, and any pending writes are discarded.

## Timing
- Write-to-effect latency: from 1 cycle up to D_old + 1 cycles. A write accepted at edge k is visible on `pending` after edge k.
- First enabled edge after reset wraps to 0: `clk_out` rises at the first enabled edge, and the first `tick` comes D cycles later.
- Period is exactly D enabled cycles. There are no glitches: `clk_out` changes only on `clk` edges, at most twice per period.
- `clk_out` is a level for use as a clock enable or for external observation only. It is never used as a clock internally.

## Structure
- Package `clk_div_pkg`: `DIV_MIN = 2`, the clamp function, and the `SEL_W` derivation.
- Sub-module `clk_div_chan`: one channel holding `cnt`, `div`, `nxt`, `pending`, `clk_out` and `tick`. Its inputs are `en`, `resync`, a write strobe already decoded by the top, and the value. The top generate-instantiates `CHANNELS` copies and decodes `div_sel`.

## Test plan
- Reset release, `en = 1`, D = 4: `clk_out` reads 1,1,0,0 repeating. `tick` is high on every 4th cycle, aligned with the second low cycle.
- Write D = 5 to channel 0 mid-period: `pending` is 1 until the wrap. The next period is 1,1,1,0,0 and `pending` drops on the wrap edge. Channel 1 is unaffected.
- Write D = 0 and then D = 1: both take effect as D = 2, giving `clk_out` 1,0 with `tick` every cycle the level is 0.
- `en` low for 3 cycles at `cnt = 2`: outputs freeze and `tick` stays 0. Counting resumes from `cnt = 3` with the period intact.
- Channels set to D = 3 and D = 6, with `resync` pulsed plus a simultaneous `div_wr` to channel 1: both `clk_out` are 1 the next cycle. The new channel-1 value remains pending until its next wrap.
- `div_sel = CHANNELS` write: no state changes. `rst_n` low mid-period with a pending write: `pending = 0` and D = `DIV_RESET` after release.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and helpers for the clock divider bank
package clk_div_pkg;

    localparam int unsigned DIV_MIN = 2;

    function automatic int sel_w(int ch);
        return ch > 1 ? $clog2(ch) : 1;
    endfunction

    function automatic int unsigned clamp_div(int unsigned d);
        return d < DIV_MIN ? DIV_MIN : d;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel with boundary-applied divisor updates
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int DIV_RESET = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             resync,
    input  logic             wr,
    input  logic [CNT_W-1:0] val,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    logic [CNT_W-1:0] cnt, div, nxt, cnt_n, div_n;
    logic             wrap;

    always_comb begin
        wrap  = en && cnt == div - CNT_W'(1);
        div_n = (resync || wrap) && pending ? nxt : div;
        cnt_n = resync || wrap ? '0 : en ? cnt + CNT_W'(1) : cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= CNT_W'(DIV_RESET - 1);
            div     <= CNT_W'(DIV_RESET);
            nxt     <= CNT_W'(DIV_RESET);
            pending <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            div     <= div_n;
            if (wr) nxt <= CNT_W'(clamp_div(32'(val)));
            pending <= wr || (pending && !resync && !wrap);
            if (resync || en) clk_out <= cnt_n < div_n - (div_n >> 1);
            tick    <= !resync && en && cnt_n == div_n - CNT_W'(1);
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: multi-channel divided-clock / tick generator with global resync
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int CHANNELS  = 2,
    parameter int CNT_W     = 16,
    parameter int DIV_RESET = 4,
    localparam int SEL_W    = sel_w(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] en,
    input  logic                resync,
    input  logic                div_wr,
    input  logic [SEL_W-1:0]    div_sel,
    input  logic [CNT_W-1:0]    div_val,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] pending
);

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_ch
            clk_div_chan #(
                .CNT_W    (CNT_W),
                .DIV_RESET(DIV_RESET)
            ) u_chan (
                .clk    (clk),
                .rst_n  (rst_n),
                .en     (en[i]),
                .resync (resync),
                .wr     (div_wr && div_sel == SEL_W'(i)),
                .val    (div_val),
                .clk_out(clk_out[i]),
                .tick   (tick[i]),
                .pending(pending[i])
            );
        end
    endgenerate

endmodule
